// File: rtl/fetch_queue_controller.sv
// Instruction-fetch controller: walks a PC into a 1-cycle ROM and buffers the
// returned words in a prefetch queue that feeds the decoder over valid/ready.
module fetch_queue_controller #(
    parameter int              INSTR_W  = 9,
    parameter int              PC_W     = 8,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    instr_pc,
    output logic [1:0]         state,
    output logic               halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  tag_pc_q;
    logic             live_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W:0]   occ_total;
    logic             issue, wr_en, pop;

    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem   [DEPTH];

    // Occupancy counts the outstanding return so a write can never find the queue full.
    assign occ_total = {1'b0, count_q} + {{CNT_W{1'b0}}, live_q};
    assign issue     = (state_q == ST_RUN) && !halt && !redirect && (occ_total < DEPTH_C);
    assign wr_en     = live_q && !redirect;
    assign pop       = instr_valid && instr_ready && !redirect;

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (halt)  state_d = ST_HALT;
            ST_HALT: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            tag_pc_q <= RESET_PC;
            live_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                pc_q <= redirect_pc;
            end else if (issue) begin
                pc_q <= pc_q + 1'b1;
            end
            live_q <= issue;
            if (issue) begin
                tag_pc_q <= pc_q;
            end
        end
    end

    // Flush beats both the same-cycle return and the same-cycle pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

    // NOTE: queue storage is deliberately not reset; an entry is only observed once the count covers it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= tag_pc_q;
        end
    end

    assign instr_valid = (count_q != '0);
    assign instr_data  = instr_valid ? data_mem[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]   : '0;
    assign state       = state_q;
    assign halted      = (state_q == ST_HALT);

endmodule
